shift_scheduler: RTL and testbench

Two-requester scheduler and sequencer for the 4-bit shift-register datapath. It arbitrates round-robin between two parallel-word requesters over valid/ready handshakes. It loads the granted word into the shift register and shifts it out serially, one bit per clock, in the direction the requester selects. It then pulses `done` and returns to idle.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_sreg.sv | 42 ++++
 rtl/shift_scheduler.sv | 121 ++++++++++++
 tb/tb_shift_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register scheduler slice.
//   state_t        : scheduler FSM encoding (IDLE, SHIFT, DONE)
//   DIR_MSB_FIRST  : direction code, MSB leaves first
//   DIR_LSB_FIRST  : direction code, LSB leaves first
//   DEFAULT_WIDTH  : default shift-register width
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_sreg.sv
// Parallel-load shift register with zero fill.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous reset, active-high (clears the register)
//   load      : load load_data (has priority over shift_en)
//   load_data : parallel word
//   shift_en  : shift one position toward the output end
//   dir       : DIR_MSB_FIRST -> output end is MSB, DIR_LSB_FIRST -> output end is LSB
//   out_bit   : bit currently at the output end
module shift_sreg
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
    output logic             out_bit
);

    logic [WIDTH-1:0] shreg_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_data;
        end else if (shift_en) begin
            if (dir == DIR_MSB_FIRST) begin
                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    assign out_bit = (dir == DIR_MSB_FIRST) ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/shift_scheduler.sv
// Two-requester round-robin scheduler that loads the granted word into a
// shift register and serializes it one bit per clock.
// Ports:
//   clk, rst_n            : clock and asynchronous active-high reset
//   req_valid[1:0]        : requester i presents a word
//   req_ready[1:0]        : requester i accepted this cycle (one-hot or zero)
//   req_data0, req_data1  : parallel words of requester 0 / 1
//   req_dir[1:0]          : per-requester direction (0 MSB first, 1 LSB first)
//   abort                 : drop the transfer in progress (SHIFT only)
//   ser_out, ser_valid    : serial bit and its qualifier
//   busy                  : high outside IDLE
//   done                  : one-cycle pulse after the last bit
//   grant_id              : requester owning the current / most recent transfer
module shift_scheduler
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [1:0]       req_dir,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic             grant_id
);

    localparam int              CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             grant_id_q;
    logic             last_grant_q;

    logic             sel_req;
    logic             accept;
    logic [WIDTH-1:0] load_word;
    logic             sreg_bit;

    // On a tie the requester that did not win last time is selected.
    always_comb begin
        sel_req = 1'b0;
        case (req_valid)
            2'b01:   sel_req = 1'b0;
            2'b10:   sel_req = 1'b1;
            2'b11:   sel_req = ~last_grant_q;
            default: sel_req = 1'b0;
        endcase
    end

    assign req_ready = (state_q == IDLE && req_valid != 2'b00)
                     ? (sel_req ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign load_word = sel_req ? req_data1 : req_data0;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dir_q        <= DIR_MSB_FIRST;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= SHIFT;
                        cnt_q        <= CNT_MAX;
                        dir_q        <= req_dir[sel_req];
                        grant_id_q   <= sel_req;
                        last_grant_q <= sel_req;
                    end
                end
                SHIFT: begin
                    // Abort keeps last_grant, so the other requester wins the next tie.
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    shift_sreg #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (load_word),
        .shift_en  (state_q == SHIFT),
        .dir       (dir_q),
        .out_bit   (sreg_bit)
    );

    // Outputs decode straight from the state register.
    assign ser_valid = (state_q == SHIFT);
    assign ser_out   = ser_valid & sreg_bit;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_shift_scheduler.sv
module tb_shift_scheduler;

    localparam int W  = 4;
    localparam int NR = 500;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_data0;
    logic [W-1:0] req_data1;
    logic [1:0]   req_dir;
    logic         abort;
    logic         ser_out;
    logic         ser_valid;
    logic         busy;
    logic         done;
    logic         grant_id;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       id;
        logic [3:0] word;
        logic       dir;
        logic [3:0] seq;   // expected serial bits in time order, leftmost first
    } vec_t;

    vec_t tbl[5];

    // Random-phase reference model state
    bit           e_sv   [0:NR+W+4];
    bit           e_so   [0:NR+W+4];
    bit           e_busy [0:NR+W+4];
    bit           e_done [0:NR+W+4];
    int           free_c;
    int           acc_c;
    logic         last_m;
    logic         mgid;
    logic         pv  [2];
    logic [W-1:0] pd  [2];
    logic         pdr [2];
    logic         sel_m;
    logic         ab;
    logic [1:0]   exp_ready;
    int           ndone;
    int           done_cyc [3];
    logic         done_gid [3];

    shift_scheduler #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_dir   (req_dir),
        .abort     (abort),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        req_dir   = 2'b00;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        chk(name, done, 1);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b0, 4'b1011, 1'b0, 4'b1011};
        tbl[1] = '{1'b1, 4'b1011, 1'b1, 4'b1101};
        tbl[2] = '{1'b0, 4'b0110, 1'b1, 4'b0110};
        tbl[3] = '{1'b1, 4'b1000, 1'b0, 4'b1000};
        tbl[4] = '{1'b0, 4'b0001, 1'b1, 4'b1000};

        // Reset values
        rst_n     = 1'b1;
        req_valid = 2'b11;
        req_data0 = '0;
        req_data1 = '0;
        req_dir   = 2'b00;
        abort     = 1'b0;
        #12;
        chk("rst_ser_out", ser_out, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_ready_tie", req_ready, 2'b01);
        req_valid = 2'b10;
        #1;
        chk("rst_ready_single1", req_ready, 2'b10);
        do_reset();

        // Table-driven single transfers
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            req_valid = tbl[r].id ? 2'b10 : 2'b01;
            if (tbl[r].id) begin
                req_data1 = tbl[r].word;
                req_data0 = ~tbl[r].word;
                req_dir   = {tbl[r].dir, ~tbl[r].dir};
            end else begin
                req_data0 = tbl[r].word;
                req_data1 = ~tbl[r].word;
                req_dir   = {~tbl[r].dir, tbl[r].dir};
            end
            #1;
            chk("tbl_ready", req_ready, {tbl[r].id, ~tbl[r].id});
            @(negedge clk);
            chk("tbl_ready_drop", req_ready, 2'b00);
            chk("tbl_grant_id", grant_id, tbl[r].id);
            req_valid = 2'b00;
            for (int n = 0; n < 4; n++) begin
                chk("tbl_ser_valid", ser_valid, 1);
                chk("tbl_ser_out", ser_out, tbl[r].seq[3-n]);
                chk("tbl_no_done", done, 0);
                @(negedge clk);
            end
            chk("tbl_done", done, 1);
            chk("tbl_done_ser_valid", ser_valid, 0);
            chk("tbl_done_busy", busy, 1);
            @(negedge clk);
            chk("tbl_done_pulse", done, 0);
            chk("tbl_idle_busy", busy, 0);
        end

        // Fairness: both requesters held valid for three words
        do_reset();
        @(negedge clk);
        req_valid = 2'b11;
        req_data0 = 4'hA;
        req_data1 = 4'h5;
        req_dir   = 2'b00;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cyc[ndone] = c;
                done_gid[ndone] = grant_id;
                ndone++;
                if (ndone == 3) break;
            end
        end
        req_valid = 2'b00;
        chk("fair_ndone", ndone, 3);
        if (ndone == 3) begin
            chk("fair_gid0", done_gid[0], 0);
            chk("fair_gid1", done_gid[1], 1);
            chk("fair_gid2", done_gid[2], 0);
            chk("fair_space1", done_cyc[1] - done_cyc[0], 6);
            chk("fair_space2", done_cyc[2] - done_cyc[1], 6);
        end
        @(negedge clk);
        @(negedge clk);

        // Abort on the second SHIFT cycle
        do_reset();
        @(negedge clk);
        req_valid = 2'b01;
        req_data0 = 4'b1111;
        req_dir   = 2'b00;
        @(negedge clk);
        chk("abort_sv1", ser_valid, 1);
        req_valid = 2'b00;
        @(negedge clk);
        chk("abort_sv2", ser_valid, 1);
        abort     = 1'b1;
        req_valid = 2'b11;
        req_data1 = 4'b0101;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_sv_drop", ser_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        #1;
        chk("abort_ready_other", req_ready, 2'b10);
        @(negedge clk);
        chk("abort_next_gid", grant_id, 1);
        chk("abort_next_sv", ser_valid, 1);
        chk("abort_next_bit0", ser_out, 0);
        req_valid = 2'b00;
        wait_done("abort_next_done");

        // Reset mid-transfer
        do_reset();
        @(negedge clk);
        req_valid = 2'b01;
        req_data0 = 4'hF;
        req_dir   = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        chk("mrst_pre_sv", ser_valid, 1);
        chk("mrst_pre_so", ser_out, 1);
        #2;
        rst_n = 1'b1;
        #1;
        chk("mrst_sv", ser_valid, 0);
        chk("mrst_so", ser_out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_gid", grant_id, 0);
        req_valid = 2'b11;
        #1;
        chk("mrst_ready_tie", req_ready, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_after_gid", grant_id, 0);
        chk("mrst_after_sv", ser_valid, 1);
        req_valid = 2'b00;
        wait_done("mrst_after_done");

        // Input stability: inputs change after accept
        @(negedge clk);
        req_valid = 2'b01;
        req_data0 = 4'b1001;
        req_dir   = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        req_data0 = 4'b0110;
        req_dir   = 2'b11;
        for (int n = 0; n < 4; n++) begin
            chk("stab_ser_out", ser_out, (n == 0 || n == 3) ? 1 : 0);
            @(negedge clk);
        end
        chk("stab_done", done, 1);
        @(negedge clk);

        // Randomized traffic against the transaction model
        do_reset();
        free_c = 0;
        acc_c  = -100;
        last_m = 1'b1;
        mgid   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pv[i]  = 1'b0;
            pd[i]  = '0;
            pdr[i] = 1'b0;
        end
        for (int c = 0; c < NR; c++) begin
            @(negedge clk);
            chk("rnd_ser_valid", ser_valid, e_sv[c]);
            if (e_sv[c]) chk("rnd_ser_out", ser_out, e_so[c]);
            chk("rnd_done", done, e_done[c]);
            chk("rnd_busy", busy, e_busy[c]);
            chk("rnd_grant_id", grant_id, mgid);
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i]  = 1'b1;
                    pd[i]  = W'($urandom);
                    pdr[i] = 1'($urandom);
                end
            end
            req_valid = {pv[1], pv[0]};
            req_data0 = pd[0];
            req_data1 = pd[1];
            req_dir   = {pdr[1], pdr[0]};
            ab        = ($urandom_range(0, 11) == 0);
            abort     = ab;
            #1;
            exp_ready = 2'b00;
            sel_m     = 1'b0;
            if (c >= free_c && (pv[0] || pv[1])) begin
                if (pv[0] && pv[1]) sel_m = ~last_m;
                else                sel_m = pv[1];
                exp_ready = sel_m ? 2'b10 : 2'b01;
            end
            chk("rnd_ready", req_ready, exp_ready);
            if (exp_ready != 2'b00) begin
                for (int n = 0; n < W; n++) begin
                    e_sv[c+1+n]   = 1'b1;
                    e_busy[c+1+n] = 1'b1;
                    e_so[c+1+n]   = pdr[sel_m] ? pd[sel_m][n] : pd[sel_m][W-1-n];
                end
                e_done[c+W+1] = 1'b1;
                e_busy[c+W+1] = 1'b1;
                free_c = c + W + 2;
                acc_c  = c;
                last_m = sel_m;
                mgid   = sel_m;
                pv[sel_m] = 1'b0;
            end else if (ab && c > acc_c && c <= acc_c + W) begin
                for (int k = c + 1; k <= acc_c + W + 1; k++) begin
                    e_sv[k]   = 1'b0;
                    e_busy[k] = 1'b0;
                    e_done[k] = 1'b0;
                end
                free_c = c + 1;
            end
        end
        req_valid = 2'b00;
        abort     = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
